imem_loader: RTL and testbench

- Writer side of the instruction-memory interface. The control unit drives IM in read mode (InsMemRW=1); this block drives IM in write mode (InsMemRW=0) to load a program before execution.
- Accepts a byte stream with a valid/ready handshake. The stream is a 16-bit word-count header followed by big-endian instruction words.
- Assembles each 32-bit word and writes it to IM at consecutive word-aligned byte addresses.
- Holds the CPU (forces PC hold) from start until load completes.

---
 rtl/imem_loader_if.sv | 29 ++
 rtl/imem_loader.sv | 174 +++++++++++++++++
 tb/tb_imem_loader.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream input, IM write port and status lines of the
// instruction-memory loader. The loader uses the slave modport and its
// driver (controller or bench) uses the master modport.
interface imem_loader_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              start;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              err;
    logic [15:0]       words_loaded;

    modport master (
        output start, in_data, in_valid,
        input  in_ready, im_we, im_addr, im_wdata, cpu_hold, busy, done, err, words_loaded
    );

    modport slave (
        input  start, in_data, in_valid,
        output in_ready, im_we, im_addr, im_wdata, cpu_hold, busy, done, err, words_loaded
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: writer side of the instruction memory. Takes a byte stream
// (16-bit word count, then big-endian 32-bit words), writes each word to IM
// at consecutive word-aligned addresses and holds the CPU until the load ends.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned MAX_WORDS = 64
) (
    input  logic         CLK,
    input  logic         Reset,
    imem_loader_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DATA   = 3'd3,
        S_WRITE  = 3'd4,
        S_DONE   = 3'd5,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_ERR    = 3'd6,
        S_CSUM   = 3'd7
`else
        S_ERR    = 3'd6
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] n_q, n_d;          // requested word count
    logic [31:0] word_q, word_d;    // word being assembled, MSB first
    logic [1:0]  bidx_q, bidx_d;    // byte position inside the word
    logic [15:0] wcnt_q, wcnt_d;    // words written in this load
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;    // running XOR of header and data bytes
`endif

    logic        in_ready;
    logic        im_we;
    logic [15:0] n_full;

    // Next-state and handshake decode; every target gets its default first.
    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        word_d   = word_q;
        bidx_d   = bidx_q;
        wcnt_d   = wcnt_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d   = csum_q;
`endif
        in_ready = 1'b0;
        im_we    = 1'b0;
        n_full   = {n_q[15:8], bus.in_data};

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (bus.start) begin
                    state_d = S_LEN_HI;
                    n_d     = '0;
                    word_d  = '0;
                    bidx_d  = '0;
                    wcnt_d  = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            S_LEN_HI: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    n_d[15:8] = bus.in_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d    = csum_q ^ bus.in_data;
`endif
                    state_d   = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    n_d = n_full;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ bus.in_data;
`endif
                    // The length is judged on the byte being accepted, so the
                    // address range is bounded before any write can happen.
                    if (n_full == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = S_CSUM;
`else
                        state_d = S_DONE;
`endif
                    end else if (n_full > 16'(MAX_WORDS)) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    word_d = {word_q[23:0], bus.in_data};
                    bidx_d = bidx_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ bus.in_data;
`endif
                    if (bidx_q == 2'd3) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                im_we  = 1'b1;
                wcnt_d = wcnt_q + 16'd1;
                if (wcnt_q + 16'd1 == n_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = S_CSUM;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    state_d = S_DATA;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_d = (bus.in_data == csum_q) ? S_DONE : S_ERR;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; Reset abandons any partial word.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            word_q  <= '0;
            bidx_q  <= '0;
            wcnt_q  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            word_q  <= word_d;
            bidx_q  <= bidx_d;
            wcnt_q  <= wcnt_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.im_we        = im_we;
    assign bus.im_addr      = {wcnt_q[ADDR_W-3:0], 2'b00};
    assign bus.im_wdata     = word_q;
    assign bus.cpu_hold     = (state_q != S_DONE);
    assign bus.busy         = !(state_q inside {S_IDLE, S_DONE, S_ERR});
    assign bus.done         = (state_q == S_DONE);
    assign bus.err          = (state_q == S_ERR);
    assign bus.words_loaded = wcnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed and randomized loads of imem_loader, checked each
// cycle against a count-based model of the stream protocol.
module tb_imem_loader;
    localparam int MAXW = 64;

    logic CLK = 1'b0;
    logic Reset;
    always #5 CLK = ~CLK;

    imem_loader_if #(.ADDR_W(8)) bus ();

    imem_loader #(.ADDR_W(8), .MAX_WORDS(MAXW)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: mode 0 idle, 1 loading, 2 done, 3 err; k = bytes consumed,
    // w = words written, n = requested count.
    int         m_mode = 0;
    int         m_k = 0;
    int         m_w = 0;
    int         m_n = 0;
    logic [7:0] m_hi = '0;
    logic [7:0] m_cs = '0;
    logic [7:0] m_data [0:255];
    logic       mon_en = 1'b0;

    logic [7:0]  src [$];
    logic [7:0]  wr_addr [$];
    logic [31:0] wr_data [$];
    int          valid_mode = 0;
    logic        tog = 1'b0;
    logic        rnd_start = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Compare DUT against the model, then advance the model by one edge.
    always @(negedge CLK) begin : mon
        logic        e_rdy, e_we, wrph, csph;
        logic [31:0] e_wd;
        int          e_addr, nn;
        logic [7:0]  b;
        if (mon_en) begin
            e_rdy = 0; e_we = 0; wrph = 0; csph = 0; e_wd = '0; e_addr = 0;
            if (m_mode == 1) begin
                if (m_k < 2) e_rdy = 1;
                else if (m_w == m_n) begin csph = 1; e_rdy = 1; end
                else if (m_k - 2 == 4 * (m_w + 1)) begin
                    wrph = 1; e_we = 1; e_addr = 4 * m_w;
                    e_wd = {m_data[4*m_w], m_data[4*m_w+1], m_data[4*m_w+2], m_data[4*m_w+3]};
                end
                else e_rdy = 1;
            end
            chk("in_ready", 32'(bus.in_ready), 32'(e_rdy));
            chk("im_we", 32'(bus.im_we), 32'(e_we));
            chk("cpu_hold", 32'(bus.cpu_hold), 32'(m_mode != 2));
            chk("busy", 32'(bus.busy), 32'(m_mode == 1));
            chk("done", 32'(bus.done), 32'(m_mode == 2));
            chk("err", 32'(bus.err), 32'(m_mode == 3));
            chk("words_loaded", 32'(bus.words_loaded), 32'(m_w));
            if (e_we) begin
                chk("im_addr", 32'(bus.im_addr), 32'(e_addr));
                chk("im_wdata", bus.im_wdata, e_wd);
            end
            if (bus.im_we === 1'b1) begin
                wr_addr.push_back(bus.im_addr);
                wr_data.push_back(bus.im_wdata);
            end

            if (Reset) begin
                m_mode = 0; m_k = 0; m_w = 0;
            end else if (bus.start && m_mode != 1) begin
                m_mode = 1; m_k = 0; m_w = 0; m_n = 0; m_cs = '0;
            end else if (m_mode == 1) begin
                if (wrph) begin
                    m_w++;
`ifndef IMEM_LOADER_CHECKSUM_EN
                    if (m_w == m_n) m_mode = 2;
`endif
                end else if (bus.in_valid) begin
                    b = bus.in_data;
                    if (src.size() > 0) void'(src.pop_front());
                    if (csph) begin
                        m_mode = (b == m_cs) ? 2 : 3;
                    end else begin
                        m_cs ^= b;
                        if (m_k == 0) m_hi = b;
                        else if (m_k == 1) begin
                            nn = int'({m_hi, b});
                            m_n = nn;
`ifndef IMEM_LOADER_CHECKSUM_EN
                            if (nn == 0) m_mode = 2;
`endif
                            if (nn > MAXW) m_mode = 3;
                        end else m_data[m_k-2] = b;
                        m_k++;
                    end
                end
            end
        end
    end

    task automatic drive_next();
        logic v;
        case (valid_mode)
            0: v = 1'b1;
            1: begin tog = !tog; v = tog; end
            default: v = ($urandom_range(0, 99) < 60);
        endcase
        if (src.size() == 0) v = 1'b0;
        bus.in_valid = v;
        bus.in_data  = v ? src[0] : 8'($urandom);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        bus.start = 1'b0;
        drive_next();
    endtask

    task automatic launch();
        wr_addr.delete();
        wr_data.delete();
        bus.start = 1'b1;
        step();
    endtask

    task automatic wait_end(input int budget, output int cyc);
        cyc = 0;
        while (m_mode == 1 && cyc < budget) begin
            if (rnd_start && m_k >= 2 && m_n >= 2 && m_w <= m_n - 2 && $urandom_range(0, 7) == 0)
                bus.start = 1'b1;
            step();
            cyc++;
        end
        checks++;
        if (m_mode == 1) begin
            errors++;
            $display("FAIL load_timeout actual=busy required=finished t=%0t", $time);
        end
    endtask

    task automatic add_csum();
`ifdef IMEM_LOADER_CHECKSUM_EN
        logic [7:0] c;
        c = '0;
        foreach (src[i]) c ^= src[i];
        src.push_back(c);
`endif
    endtask

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : drive
        int cyc, nn, good_cs;
        logic [31:0] wd;
        logic [31:0] words [$];
        logic [7:0] cs;
        logic ok;

        Reset = 1'b1;
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
        @(posedge CLK); #1;
        mon_en = 1'b1;
        step();
        Reset = 1'b0;
        repeat (3) step();
        chk("rst_cpu_hold", 32'(bus.cpu_hold), 32'd1);
        chk("rst_im_we", 32'(bus.im_we), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);

        // Single word, valid held high.
        valid_mode = 0;
        src = '{8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05};
        add_csum();
        launch();
        wait_end(100, cyc);
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk("t1_cycles", 32'(cyc), 32'd8);
`else
        chk("t1_cycles", 32'(cyc), 32'd7);
`endif
        chk("t1_done", 32'(bus.done), 32'd1);
        chk("t1_cpu_hold", 32'(bus.cpu_hold), 32'd0);
        chk("t1_words", 32'(bus.words_loaded), 32'd1);
        chk("t1_nwr", 32'(wr_addr.size()), 32'd1);
        if (wr_addr.size() == 1) begin
            chk("t1_addr", 32'(wr_addr[0]), 32'h00);
            chk("t1_data", wr_data[0], 32'h20080005);
        end

        // Three words, in_valid toggling.
        valid_mode = 1;
        src = '{8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44,
                8'h8C, 8'h01, 8'h00, 8'h00};
        add_csum();
        launch();
        wait_end(200, cyc);
        chk("t2_done", 32'(bus.done), 32'd1);
        chk("t2_nwr", 32'(wr_addr.size()), 32'd3);
        if (wr_addr.size() == 3) begin
            chk("t2_addr0", 32'(wr_addr[0]), 32'h00);
            chk("t2_addr1", 32'(wr_addr[1]), 32'h04);
            chk("t2_addr2", 32'(wr_addr[2]), 32'h08);
            chk("t2_data0", wr_data[0], 32'hAABBCCDD);
            chk("t2_data1", wr_data[1], 32'h11223344);
            chk("t2_data2", wr_data[2], 32'h8C010000);
        end

        // Oversized header.
        valid_mode = 0;
        src = '{8'h00, 8'h41, 8'h12, 8'h34};
        launch();
        wait_end(50, cyc);
        repeat (3) step();
        chk("t3_err", 32'(bus.err), 32'd1);
        chk("t3_cpu_hold", 32'(bus.cpu_hold), 32'd1);
        chk("t3_in_ready", 32'(bus.in_ready), 32'd0);
        chk("t3_nwr", 32'(wr_addr.size()), 32'd0);
        chk("t3_left", 32'(src.size()), 32'd2);
        src.delete();

        // Reset in the middle of a load, then an empty load.
        src = '{8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        launch();
        cyc = 0;
        while (m_k < 7 && cyc < 100) begin step(); cyc++; end
        chk("t4_reached", 32'(m_k), 32'd7);
        Reset = 1'b1;
        src.delete();
        step();
        Reset = 1'b0;
        chk("t4_busy", 32'(bus.busy), 32'd0);
        chk("t4_words", 32'(bus.words_loaded), 32'd0);
        chk("t4_cpu_hold", 32'(bus.cpu_hold), 32'd1);
        chk("t4_nwr", 32'(wr_addr.size()), 32'd1);
        src = '{8'h00, 8'h00};
        add_csum();
        launch();
        wait_end(50, cyc);
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk("t4_n0_cycles", 32'(cyc), 32'd3);
`else
        chk("t4_n0_cycles", 32'(cyc), 32'd2);
`endif
        chk("t4_n0_done", 32'(bus.done), 32'd1);
        chk("t4_n0_words", 32'(bus.words_loaded), 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum pass and fail with a hand-computed byte.
        src = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        launch();
        wait_end(50, cyc);
        chk("t5_good_done", 32'(bus.done), 32'd1);
        src = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h06};
        launch();
        wait_end(50, cyc);
        chk("t5_bad_err", 32'(bus.err), 32'd1);
`endif

        // Randomized loads.
        valid_mode = 2;
        for (int t = 0; t < 25; t++) begin
            case ($urandom_range(0, 9))
                0:       nn = 0;
                1:       nn = MAXW;
                2:       nn = MAXW + 1 + int'($urandom_range(0, 2000));
                default: nn = int'($urandom_range(1, 16));
            endcase
            words.delete();
            src.delete();
            src.push_back(8'(nn >> 8));
            src.push_back(8'(nn));
            cs = 8'(nn >> 8) ^ 8'(nn);
            ok = (nn <= MAXW);
            if (nn <= MAXW) begin
                for (int i = 0; i < nn; i++) begin
                    wd = $urandom;
                    words.push_back(wd);
                    for (int j = 3; j >= 0; j--) begin
                        src.push_back(wd[j*8 +: 8]);
                        cs ^= wd[j*8 +: 8];
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                good_cs = ($urandom_range(0, 4) != 0) ? 1 : 0;
                src.push_back(good_cs != 0 ? cs : cs ^ 8'(1 << $urandom_range(0, 7)));
                ok = (good_cs != 0);
`endif
            end else begin
                repeat (3) src.push_back(8'($urandom));
            end
            rnd_start = 1'b1;
            launch();
            wait_end(3000, cyc);
            rnd_start = 1'b0;
            chk("rnd_done", 32'(bus.done), 32'(ok));
            chk("rnd_err", 32'(bus.err), 32'(!ok));
            chk("rnd_nwr", 32'(wr_addr.size()), 32'(words.size()));
            chk("rnd_words", 32'(bus.words_loaded), 32'(words.size()));
            if (wr_addr.size() == words.size()) begin
                foreach (words[i]) begin
                    chk("rnd_addr", 32'(wr_addr[i]), 32'(4 * i));
                    chk("rnd_data", wr_data[i], words[i]);
                end
            end
            src.delete();
            repeat (2) step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
